alu_rr_scheduler: RTL and testbench

- Shares one registered ALU datapath (add, a-b, b-a, multiply-low) between NREQ requesters.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Each accepted operation is tagged with its requester ID and carried through a shift-register tag pipeline matched to the ALU latency.
- Each result returns to its originating requester as a one-cycle response strobe.
- Sits between requester front-ends and the ALU instance. The ALU is external and cannot stall.

---
 rtl/alu_rr_scheduler.sv | 104 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency ALU between NREQ requesters.
// Each accepted op is tagged with its requester ID and the result is routed back as a one-cycle strobe.
module alu_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int DATAW   = 16,
  parameter int OPCODEW = 2,
  parameter int ALU_LAT = 2,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sched_en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OPCODEW-1:0] req_opcode,
  input  logic [NREQ*DATAW-1:0]   req_dataa,
  input  logic [NREQ*DATAW-1:0]   req_datab,
  output logic [OPCODEW-1:0]      alu_opcode,
  output logic [DATAW-1:0]        alu_dataa,
  output logic [DATAW-1:0]        alu_datab,
  output logic                    alu_issue,
  input  logic [DATAW-1:0]        alu_result,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DATAW-1:0]        rsp_result,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy
);

  logic [NREQ-1:0]    pending_reg;
  logic [IDW-1:0]     ptr_reg;
  logic [NREQ-1:0]    eligible;
  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [ALU_LAT-1:0] tag_valid_reg;
  logic [IDW-1:0]     tag_id_reg [ALU_LAT];
  logic [NREQ-1:0]    rsp_onehot;

  // One outstanding op per requester: a pending requester is masked out.
  assign eligible = sched_en ? (req_valid & ~pending_reg) : '0;
  assign busy     = |pending_reg;

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!grant_found && eligible[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign req_ready[gi]  = grant_found && (grant_id == IDW'(gi));
    assign rsp_onehot[gi] = (tag_id_reg[ALU_LAT-1] == IDW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode    <= '0;
      alu_dataa     <= '0;
      alu_datab     <= '0;
      alu_issue     <= 1'b0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_id        <= '0;
      pending_reg   <= '0;
      ptr_reg       <= IDW'(NREQ - 1);
      tag_valid_reg <= '0;
      for (int s = 0; s < ALU_LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      alu_issue <= grant_found;
      // ALU operands hold their last values when nothing is issued.
      if (grant_found) begin
        alu_opcode <= req_opcode[grant_id*OPCODEW +: OPCODEW];
        alu_dataa  <= req_dataa[grant_id*DATAW +: DATAW];
        alu_datab  <= req_datab[grant_id*DATAW +: DATAW];
        ptr_reg    <= grant_id;
      end

      tag_valid_reg[0] <= grant_found;
      tag_id_reg[0]    <= grant_id;
      for (int s = 1; s < ALU_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end

      rsp_valid <= tag_valid_reg[ALU_LAT-1] ? rsp_onehot : '0;
      if (tag_valid_reg[ALU_LAT-1]) begin
        rsp_result <= alu_result;
        rsp_id     <= tag_id_reg[ALU_LAT-1];
      end

      // Pending drops only after the response cycle, so no re-grant during it.
      pending_reg <= (pending_reg & ~rsp_valid) | req_ready;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomized and directed bench for alu_rr_scheduler with a cycle-level model of arbitration,
// pending state and response timing; a simple registered ALU stands in for the external one.
module tb_alu_rr_scheduler;
  localparam int NREQ    = 4;
  localparam int DATAW   = 16;
  localparam int OPCODEW = 2;
  localparam int ALU_LAT = 2;
  localparam int IDW     = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    sched_en = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*OPCODEW-1:0] req_opcode;
  logic [NREQ*DATAW-1:0]   req_dataa;
  logic [NREQ*DATAW-1:0]   req_datab;
  logic [OPCODEW-1:0]      alu_opcode;
  logic [DATAW-1:0]        alu_dataa;
  logic [DATAW-1:0]        alu_datab;
  logic                    alu_issue;
  logic [DATAW-1:0]        alu_result;
  logic [NREQ-1:0]         rsp_valid;
  logic [DATAW-1:0]        rsp_result;
  logic [IDW-1:0]          rsp_id;
  logic                    busy;

  logic [OPCODEW-1:0] op_i [NREQ];
  logic [DATAW-1:0]   a_i  [NREQ];
  logic [DATAW-1:0]   b_i  [NREQ];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_opcode[gi*OPCODEW +: OPCODEW] = op_i[gi];
    assign req_dataa[gi*DATAW +: DATAW]      = a_i[gi];
    assign req_datab[gi*DATAW +: DATAW]      = b_i[gi];
  end

  alu_rr_scheduler #(
    .NREQ(NREQ), .DATAW(DATAW), .OPCODEW(OPCODEW), .ALU_LAT(ALU_LAT), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_dataa(req_dataa), .req_datab(req_datab),
    .alu_opcode(alu_opcode), .alu_dataa(alu_dataa), .alu_datab(alu_datab),
    .alu_issue(alu_issue), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
  );

  // External ALU: one register stage, result valid ALU_LAT-1 cycles after operands.
  logic [DATAW-1:0] alu_q;
  always @(posedge clk) begin
    case (alu_opcode)
      2'd0:    alu_q <= alu_dataa + alu_datab;
      2'd1:    alu_q <= alu_dataa - alu_datab;
      2'd2:    alu_q <= alu_datab - alu_dataa;
      default: alu_q <= alu_dataa * alu_datab;
    endcase
  end
  assign alu_result = alu_q;

  // Reference model state
  typedef struct {
    int               due;
    int               id;
    logic [DATAW-1:0] res;
  } rsp_t;

  rsp_t             rq[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               ptr;
  int               gcyc [NREQ];
  bit               have [NREQ];
  logic             exp_issue, nxt_issue;
  logic [OPCODEW-1:0] exp_op;
  logic [DATAW-1:0] exp_a, exp_b, exp_rres;
  logic [NREQ-1:0]  exp_rv;
  logic [IDW-1:0]   exp_rid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] model_result(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = b - a;
      default: r = a * b;
    endcase
    return r[DATAW-1:0];
  endfunction

  // Requester i counts as pending from the cycle after its grant through its response cycle.
  function automatic bit is_pending(input int i);
    return have[i] && (cyc <= gcyc[i] + ALU_LAT + 1);
  endfunction

  task automatic model_reset();
    ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      have[i] = 0;
      gcyc[i] = 0;
    end
    rq.delete();
    exp_issue = 0; nxt_issue = 0;
    exp_op = '0; exp_a = '0; exp_b = '0;
    exp_rv = '0; exp_rid = '0; exp_rres = '0;
  endtask

  task automatic check_outputs();
    logic eb;
    eb = 1'b0;
    for (int i = 0; i < NREQ; i++) eb |= is_pending(i);
    check("alu_issue",  32'(alu_issue),  32'(exp_issue));
    check("alu_opcode", 32'(alu_opcode), 32'(exp_op));
    check("alu_dataa",  32'(alu_dataa),  32'(exp_a));
    check("alu_datab",  32'(alu_datab),  32'(exp_b));
    check("rsp_valid",  32'(rsp_valid),  32'(exp_rv));
    check("rsp_id",     32'(rsp_id),     32'(exp_rid));
    check("rsp_result", 32'(rsp_result), 32'(exp_rres));
    check("busy",       32'(busy),       32'(eb));
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b);
    op_i[i] = op[OPCODEW-1:0];
    a_i[i]  = a[DATAW-1:0];
    b_i[i]  = b[DATAW-1:0];
  endtask

  // One clock cycle: drive inputs, check arbitration, advance, check registered outputs.
  task automatic step(input logic en, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] er;
    int w, idx;
    sched_en  = en;
    req_valid = v;
    #1;
    er = '0;
    w  = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (w < 0 && en && v[idx[IDW-1:0]] && !is_pending(idx)) w = idx;
    end
    if (w >= 0) er[w[IDW-1:0]] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    nxt_issue = (w >= 0);
    if (w >= 0) begin
      ptr = w;
      have[w] = 1;
      gcyc[w] = cyc;
      exp_op = op_i[w];
      exp_a  = a_i[w];
      exp_b  = b_i[w];
      rq.push_back('{due: cyc + ALU_LAT + 1, id: w,
                     res: model_result(int'(op_i[w]), int'(a_i[w]), int'(b_i[w]))});
      $display("cyc %0d grant req%0d op=%0d a=%h b=%h", cyc, w, op_i[w], a_i[w], b_i[w]);
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_issue = nxt_issue;
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv   = NREQ'(1) << rq[0].id;
      exp_rid  = rq[0].id[IDW-1:0];
      exp_rres = rq[0].res;
      $display("cyc %0d expect response req%0d result=%h", cyc, rq[0].id, rq[0].res);
      void'(rq.pop_front());
    end
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sched_en  = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    $display("cyc %0d reset asserted", cyc);
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // Single op
    set_req(0, 0, 5, 3);
    step(1'b1, 4'b0001);
    idle(5);

    // Contention: opcodes 0..3 with a=7, b=2
    for (int i = 0; i < NREQ; i++) set_req(i, i, 7, 2);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b1000);
    idle(6);

    // Outstanding limit with two requesters held valid
    set_req(0, 0, 100, 1);
    set_req(2, 2, 100, 1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0101);
    idle(6);

    // Multiply truncation
    set_req(1, 3, 300, 300);
    step(1'b1, 4'b0010);
    idle(5);

    // Scheduler disabled, then enabled
    set_req(3, 1, 9, 4);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    idle(6);

    // Reset one cycle after a grant, then contention between req0 and req1
    set_req(0, 0, 11, 22);
    step(1'b1, 4'b0001);
    do_reset();
    set_req(0, 1, 50, 8);
    set_req(1, 2, 50, 8);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0010);
    idle(6);

    // Randomized traffic with occasional resets and disabled cycles
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, NREQ'($urandom_range(0, 15)));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
